// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit start validation,
// centre sampling of data bits, stop-bit check with framing-error pulse.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Framing_Err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             err_q, err_d;
  logic             active_q, active_d;
  logic             r_rx;

  assign r_rx = sync2_q;

  assign o_Rx_DV       = dv_q;
  assign o_Rx_Byte     = byte_q;
  assign o_Rx_Active   = active_q;
  assign o_Framing_Err = err_q;

  // Next-state and output logic; pulses default low so they last one cycle.
  always_comb begin
    state_d  = state_q;
    sync1_d  = i_Rx_Serial;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!r_rx) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end

      S_START: begin
        if (cnt_q < HALF) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!r_rx) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          // Line went back high before mid-bit: treat as a glitch.
          state_d  = S_IDLE;
          cnt_d    = '0;
          active_d = 1'b0;
        end
      end

      S_DATA: begin
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d          = '0;
          shift_d[idx_q] = r_rx;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
          if (r_rx) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_CLEANUP: begin
        // A stuck-low line parks here so it cannot start another frame.
        if (r_rx) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scenario tasks drive 8N1 frames and compare
// against expectations derived from frame timing and an expected-byte queue.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;
  localparam int STOP_OFS = 3 + H + 9 * C;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       active;
  logic       ferr;

  int tests;
  int fails;
  int cyc;

  // Event log collected by the monitor.
  logic [7:0] dv_log[$];
  int dv_cyc_last;
  int err_cnt;
  int both_cnt;
  int dv_long;
  int err_long;
  int bad_change;
  int act_rise_cnt;
  int act_rise_cyc;
  int act_fall_cyc;
  logic [7:0] last_good;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_Serial  (rx),
    .o_Rx_DV      (dv),
    .o_Rx_Byte    (rx_byte),
    .o_Rx_Active  (active),
    .o_Framing_Err(ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    logic       p_dv;
    logic       p_err;
    logic       p_act;
    logic [7:0] p_byte;
    p_dv = 0; p_err = 0; p_act = 0; p_byte = 0;
    dv_cyc_last = -1; err_cnt = 0; both_cnt = 0; dv_long = 0; err_long = 0;
    bad_change = 0; act_rise_cnt = 0; act_rise_cyc = -1; act_fall_cyc = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dv) begin
          dv_log.push_back(rx_byte);
          dv_cyc_last = cyc;
        end
        if (ferr) err_cnt++;
        if (dv && ferr) both_cnt++;
        if (dv && p_dv) dv_long++;
        if (ferr && p_err) err_long++;
        if (rx_byte !== p_byte && !dv) bad_change++;
        if (active && !p_act) begin
          act_rise_cnt++;
          act_rise_cyc = cyc;
        end
        if (!active && p_act) act_fall_cyc = cyc;
      end
      p_dv = dv; p_err = ferr; p_act = active; p_byte = rx_byte;
    end
  end

  // Drives one frame starting at the current negedge; line left at stop level.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (dv !== 1'b0 || ferr !== 1'b0 || active !== 1'b0 || rx_byte !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: dv=%b err=%b act=%b byte=%h, required 0 0 0 00",
               dv, ferr, active, rx_byte);
    end
    last_good = 8'h00;
  endtask

  task automatic test_single();
    int c, n0, e0, k;
    n0 = dv_log.size();
    e0 = err_cnt;
    @(negedge clk);
    c = cyc;
    k = c + 1;
    drive_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    tests++;
    if (dv_log.size() !== n0 + 1) begin
      fails++;
      $display("FAIL single_count: got %0d pulses, required 1", dv_log.size() - n0);
    end else begin
      tests++;
      if (dv_log[n0] !== 8'hA5) begin
        fails++;
        $display("FAIL single_byte: got %h, required a5", dv_log[n0]);
      end
    end
    tests++;
    if (dv_cyc_last !== k + STOP_OFS) begin
      fails++;
      $display("FAIL single_latency: dv in cycle %0d, required %0d", dv_cyc_last, k + STOP_OFS);
    end
    tests++;
    if (act_rise_cyc !== k + 2 || act_fall_cyc !== k + STOP_OFS + 1) begin
      fails++;
      $display("FAIL single_active: rise %0d fall %0d, required %0d %0d",
               act_rise_cyc, act_fall_cyc, k + 2, k + STOP_OFS + 1);
    end
    tests++;
    if (err_cnt !== e0 || dv_long !== 0) begin
      fails++;
      $display("FAIL single_pulse: err pulses %0d long dv %0d, required 0 0", err_cnt - e0, dv_long);
    end
    last_good = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int n0, e0;
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    n0 = dv_log.size();
    e0 = err_cnt;
    @(negedge clk);
    foreach (exp_q[i]) drive_frame(exp_q[i], 1'b1);
    repeat (4) @(negedge clk);
    tests++;
    if (dv_log.size() !== n0 + 3 || err_cnt !== e0) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses %0d errs, required 3 0",
               dv_log.size() - n0, err_cnt - e0);
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (dv_log[n0 + i] !== exp_q[i]) begin
          fails++;
          $display("FAIL b2b_byte%0d: got %h, required %h", i, dv_log[n0 + i], exp_q[i]);
        end
      end
    end
    last_good = 8'h3C;
  endtask

  task automatic test_glitch();
    int n0, e0, r0;
    n0 = dv_log.size();
    e0 = err_cnt;
    r0 = act_rise_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    tests++;
    if (act_rise_cnt !== r0 + 1 || active !== 1'b0) begin
      fails++;
      $display("FAIL glitch_active: rises %0d act=%b, required 1 0", act_rise_cnt - r0, active);
    end
    tests++;
    if (dv_log.size() !== n0 || err_cnt !== e0 || rx_byte !== last_good) begin
      fails++;
      $display("FAIL glitch_outputs: dv %0d err %0d byte %h, required 0 0 %h",
               dv_log.size() - n0, err_cnt - e0, rx_byte, last_good);
    end
    drive_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    tests++;
    if (dv_log.size() !== n0 + 1 || rx_byte !== 8'h5A) begin
      fails++;
      $display("FAIL glitch_next: pulses %0d byte %h, required 1 5a", dv_log.size() - n0, rx_byte);
    end
    last_good = 8'h5A;
  endtask

  task automatic test_framing();
    int n0, e0;
    n0 = dv_log.size();
    e0 = err_cnt;
    @(negedge clk);
    drive_frame(8'h81, 1'b0);
    repeat (40 * C) @(negedge clk);
    tests++;
    if (err_cnt !== e0 + 1 || err_long !== 0) begin
      fails++;
      $display("FAIL frame_err: got %0d err pulses (long %0d), required 1", err_cnt - e0, err_long);
    end
    tests++;
    if (dv_log.size() !== n0 || rx_byte !== last_good) begin
      fails++;
      $display("FAIL frame_byte: dv %0d byte %h, required 0 %h", dv_log.size() - n0, rx_byte, last_good);
    end
    tests++;
    if (active !== 1'b1) begin
      fails++;
      $display("FAIL frame_hold: active=%b while line low, required 1", active);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL frame_release: active=%b after line high, required 0", active);
    end
    drive_frame(8'h42, 1'b1);
    repeat (4) @(negedge clk);
    tests++;
    if (dv_log.size() !== n0 + 1 || rx_byte !== 8'h42 || err_cnt !== e0 + 1) begin
      fails++;
      $display("FAIL frame_next: pulses %0d byte %h errs %0d, required 1 42 1",
               dv_log.size() - n0, rx_byte, err_cnt - e0);
    end
    last_good = 8'h42;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int n0;
    b = 8'hC3;
    @(negedge clk);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = b[4];
    repeat (C / 2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (dv !== 1'b0 || ferr !== 1'b0 || active !== 1'b0 || rx_byte !== 8'h00) begin
      fails++;
      $display("FAIL midreset_state: dv=%b err=%b act=%b byte=%h, required 0 0 0 00",
               dv, ferr, active, rx_byte);
    end
    repeat (3) @(negedge clk);
    rx = 1'b1;
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    n0 = dv_log.size();
    drive_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    tests++;
    if (dv_log.size() !== n0 + 1 || rx_byte !== 8'h7E) begin
      fails++;
      $display("FAIL midreset_next: pulses %0d byte %h, required 1 7e", dv_log.size() - n0, rx_byte);
    end
    last_good = 8'h7E;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_q[$];
    int n0, e0, bad;
    n0 = dv_log.size();
    e0 = err_cnt;
    bad = 0;
    @(negedge clk);
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(8'(v));
      drive_frame(8'(v), 1'b1);
      repeat (C * $urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (dv_log.size() !== n0 + 256 || err_cnt !== e0) begin
      fails++;
      $display("FAIL sweep_count: pulses %0d errs %0d, required 256 0", dv_log.size() - n0, err_cnt - e0);
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (dv_log[n0 + i] !== exp_q[i]) begin
          fails++;
          bad++;
          if (bad < 8) $display("FAIL sweep_byte%0d: got %h, required %h", i, dv_log[n0 + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (both_cnt !== 0 || dv_long !== 0 || err_long !== 0) begin
      fails++;
      $display("FAIL pulse_rules: both %0d long_dv %0d long_err %0d, required 0 0 0",
               both_cnt, dv_long, err_long);
    end
    tests++;
    if (bad_change !== 0) begin
      fails++;
      $display("FAIL byte_stable: %0d changes without dv, required 0", bad_change);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    test_sweep();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the link driven by the team's 8N1 transmitter (8 data bits LSB first, 1 start bit, 1 stop bit, no parity).
- Synchronises the asynchronous serial line, validates the start bit at mid-bit, samples each bit at its centre, and checks the stop bit.
- Delivers each received byte with a one-cycle valid pulse to downstream logic (command parser / loopback path). Frames with a bad stop bit are flagged and discarded.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per UART bit = f(i_Clock)/baud. Must be ≥ 4.
- Counter width is $clog2(CLKS_PER_BIT) bits minimum. It must hold CLKS_PER_BIT-1 without truncation.
- H = (CLKS_PER_BIT-1)/2, integer divide; this is the half-bit point.

Ports:
- i_Clock, input, 1, single system clock; all logic on the rising edge.
- i_Reset, input, 1, reset, asynchronous, active-high.
- i_Rx_Serial, input, 1, asynchronous serial line; idles high.
- o_Rx_DV, output, 1, one-cycle pulse: o_Rx_Byte holds a new valid byte.
- o_Rx_Byte, output, 8, last correctly framed byte.
- o_Rx_Active, output, 1, high while a frame is being received.
- o_Framing_Err, output, 1, one-cycle pulse: stop bit sampled low, byte discarded.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - State = IDLE; both synchroniser flops = 1; counters = 0.
  - o_Rx_DV = 0, o_Rx_Byte = 8'h00, o_Rx_Active = 0, o_Framing_Err = 0.
  - A partially received frame is dropped. Reception resumes at the next falling edge after reset is released.
- Synchroniser: two flops feed r_Rx. All FSM decisions use r_Rx only, never the raw pin.
- IDLE:
  - Counters cleared.
  - r_Rx == 0 → START, count = 0, o_Rx_Active = 1.
- START:
  - count < H → count+1.
  - count == H: if r_Rx == 0 → DATA, count = 0, bit index = 0. Otherwise (glitch) → IDLE, o_Rx_Active = 0, no outputs pulsed.
- DATA:
  - count < CLKS_PER_BIT-1 → count+1.
  - count == CLKS_PER_BIT-1: shift register[bit index] ← r_Rx, count = 0.
  - Bit index 7 → STOP; otherwise bit index+1.
- STOP:
  - Count as in DATA.
  - At count == CLKS_PER_BIT-1, sample r_Rx:
    - r_Rx == 1: o_Rx_Byte ← shift register, o_Rx_DV = 1.
    - r_Rx == 0: o_Framing_Err = 1; o_Rx_Byte unchanged.
  - → CLEANUP in both cases.
- CLEANUP:
  - o_Rx_DV and o_Framing_Err cleared, so each pulse lasts exactly one cycle.
  - r_Rx == 1 → IDLE, o_Rx_Active = 0.
  - r_Rx == 0 (break / stuck-low line) → stay in CLEANUP, o_Rx_Active held 1, until r_Rx == 1. A held-low line never produces a second frame or a second error pulse.
- Latency: let edge k be the first clock edge that samples the pin low. START is entered at edge k+2 and the stop sample occurs at edge k+3+H+9*CLKS_PER_BIT. o_Rx_DV / o_Framing_Err are high in the following cycle.
- Back-to-back frames:
  - After a good stop bit, CLEANUP lasts 1 cycle, then IDLE.
  - A start edge arriving half a bit after the stop sample must be caught with no lost byte.
- o_Rx_DV and o_Framing_Err are never high in the same cycle.
- o_Rx_Byte changes only in the cycle o_Rx_DV rises.

Test Plan (CLKS_PER_BIT = 16, H = 7; the bench drives each bit for 16 clocks):
1. Frame 8'hA5 with a good stop bit → o_Rx_DV pulses exactly 1 cycle; o_Rx_Byte = 8'hA5; the pulse appears in the cycle after edge k+154; o_Rx_Active high from edge k+2 until CLEANUP exits; o_Framing_Err stays 0.
2. Frames 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap → three o_Rx_DV pulses; bytes 00, FF, 3C in order; no o_Framing_Err.
3. Low glitch of 4 clocks on an idle line → return to IDLE at the half-bit check; o_Rx_Active pulses briefly; no o_Rx_DV, no o_Framing_Err; o_Rx_Byte unchanged. A following frame 8'h5A is received correctly.
4. Frame 8'h81 with the stop bit driven low, then the line held low for 40 bit times, then released high → exactly one o_Framing_Err pulse; no o_Rx_DV; o_Rx_Byte keeps its previous value; o_Rx_Active stays 1 until the line returns high. A subsequent frame 8'h42 is received correctly.
5. i_Reset asserted asynchronously (not on a clock edge) during data bit 4 of frame 8'hC3 → all outputs 0 immediately, o_Rx_Byte = 00. After release with the line high, frame 8'h7E yields o_Rx_Byte = 7E with a single o_Rx_DV pulse.
6. Sweep all 256 byte values, with a random idle gap of 0–3 bit times between frames → 256 o_Rx_DV pulses, each byte matching in order, zero framing errors.
